gen_class_ctrl: RTL and testbench

- Sequencer that sits in front of gen_class and owns its op, trained_label and in_hv controls.
- Accepts labelled training or inference hypervectors over a valid/ready stream and drives exactly one bundling cycle per training sample.
- For inference samples, waits out the classifier latency, captures predicted_label and returns it over a valid/ready result channel.
- Keeps per-class training counters, and keeps op high whenever the controller is not training, so associative memory is never corrupted by idle cycles.

---
 rtl/gen_class_ctrl.sv | 130 +++++++++++++
 tb/tb_gen_class_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_class_ctrl.sv
// Sequencer in front of gen_class: drives one bundling cycle per training sample
// and returns gen_class predictions for inference samples over a result channel.
module gen_class_ctrl #(
    parameter int unsigned DIMENSIONS = 10000,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned INFER_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DIMENSIONS-1:0] s_hv,
    input  logic                  s_mode,
    input  logic                  s_label,
    input  logic                  clr_cnt,
    output logic                  cls_op,
    output logic                  cls_trained_label,
    output logic [DIMENSIONS-1:0] cls_hv,
    input  logic                  cls_predicted_label,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  r_label,
    output logic                  busy,
    output logic [CNT_W-1:0]      train_cnt_ns,
    output logic [CNT_W-1:0]      train_cnt_s
);

    localparam int unsigned       WAIT_W   = 4;
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(INFER_LAT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, TRAIN, WAIT, RESULT} state_t;

    state_t                  state, state_d;
    logic [WAIT_W-1:0]       wait_cnt, wait_cnt_d;
    logic                    cls_op_d, cls_trained_label_d;
    logic [DIMENSIONS-1:0]   cls_hv_d;
    logic                    r_valid_d, r_label_d;
    logic [CNT_W-1:0]        train_cnt_ns_d, train_cnt_s_d;
    logic                    accept;

    assign s_ready = (state == IDLE) & ~nrst;
    assign busy    = (state != IDLE);
    assign accept  = s_valid & s_ready;

    // State and registered outputs; cls_op resets high so memory is never bundled idly
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            cls_op            <= 1'b1;
            cls_trained_label <= 1'b0;
            cls_hv            <= '0;
            r_valid           <= 1'b0;
            r_label           <= 1'b0;
            train_cnt_ns      <= '0;
            train_cnt_s       <= '0;
        end else begin
            state             <= state_d;
            wait_cnt          <= wait_cnt_d;
            cls_op            <= cls_op_d;
            cls_trained_label <= cls_trained_label_d;
            cls_hv            <= cls_hv_d;
            r_valid           <= r_valid_d;
            r_label           <= r_label_d;
            train_cnt_ns      <= train_cnt_ns_d;
            train_cnt_s       <= train_cnt_s_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d             = state;
        wait_cnt_d          = wait_cnt;
        cls_op_d            = cls_op;
        cls_trained_label_d = cls_trained_label;
        cls_hv_d            = cls_hv;
        r_valid_d           = r_valid;
        r_label_d           = r_label;
        train_cnt_ns_d      = train_cnt_ns;
        train_cnt_s_d       = train_cnt_s;

        case (state)
            IDLE: begin
                if (accept) begin
                    cls_hv_d = s_hv;
                    if (!s_mode) begin
                        state_d             = TRAIN;
                        cls_op_d            = 1'b0;
                        cls_trained_label_d = s_label;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = '0;
                    end
                end
            end
            TRAIN: begin
                cls_op_d = 1'b1;
                state_d  = IDLE;
                if (cls_trained_label) begin
                    if (train_cnt_s != CNT_MAX) train_cnt_s_d = train_cnt_s + CNT_W'(1);
                end else begin
                    if (train_cnt_ns != CNT_MAX) train_cnt_ns_d = train_cnt_ns + CNT_W'(1);
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_END) begin
                    r_label_d = cls_predicted_label;
                    r_valid_d = 1'b1;
                    state_d   = RESULT;
                end else begin
                    wait_cnt_d = wait_cnt + WAIT_W'(1);
                end
            end
            RESULT: begin
                if (r_valid && r_ready) begin
                    r_valid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_cnt) begin
            train_cnt_ns_d = '0;
            train_cnt_s_d  = '0;
        end
    end

endmodule

// File: tb/tb_gen_class_ctrl.sv
// Bench for gen_class_ctrl: table-driven samples with a result scoreboard, plus
// hand-written backpressure, saturation, clear and reset corner cases.
module tb_gen_class_ctrl;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          nrst = 1'b1;
    logic          s_valid = 1'b0, s_mode = 1'b0, s_label = 1'b0, clr_cnt = 1'b0;
    logic          r_ready = 1'b1;
    logic [DW-1:0] s_hv = '0;
    logic          pred = 1'b0;

    logic          s_ready, cls_op, cls_trained_label, r_valid, r_label, busy;
    logic [DW-1:0] cls_hv;
    logic [15:0]   train_cnt_ns, train_cnt_s;

    logic          d2_s_ready, d2_cls_op, d2_tl, d2_r_valid, d2_r_label, d2_busy;
    logic [DW-1:0] d2_cls_hv;
    logic [1:0]    d2_cnt_ns, d2_cnt_s;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    // Classifier model: registers parity of in_hv one cycle after it is presented with op=1
    always @(posedge clk) if (cls_op) pred <= ^cls_hv;

    gen_class_ctrl #(.DIMENSIONS(DW), .CNT_W(16), .INFER_LAT(1)) dut (
        .clk(clk), .nrst(nrst), .s_valid(s_valid), .s_ready(s_ready), .s_hv(s_hv),
        .s_mode(s_mode), .s_label(s_label), .clr_cnt(clr_cnt), .cls_op(cls_op),
        .cls_trained_label(cls_trained_label), .cls_hv(cls_hv),
        .cls_predicted_label(pred), .r_valid(r_valid), .r_ready(r_ready),
        .r_label(r_label), .busy(busy), .train_cnt_ns(train_cnt_ns),
        .train_cnt_s(train_cnt_s));

    gen_class_ctrl #(.DIMENSIONS(DW), .CNT_W(2), .INFER_LAT(1)) dut2 (
        .clk(clk), .nrst(nrst), .s_valid(s_valid), .s_ready(d2_s_ready), .s_hv(s_hv),
        .s_mode(s_mode), .s_label(s_label), .clr_cnt(clr_cnt), .cls_op(d2_cls_op),
        .cls_trained_label(d2_tl), .cls_hv(d2_cls_hv),
        .cls_predicted_label(pred), .r_valid(d2_r_valid), .r_ready(r_ready),
        .r_label(d2_r_label), .busy(d2_busy), .train_cnt_ns(d2_cnt_ns),
        .train_cnt_s(d2_cnt_s));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one sample from IDLE; returns at the negedge after the accept edge
    task automatic send(input logic mode, input logic label, input logic [DW-1:0] hv);
        int n = 0;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_mode  = mode;
        s_label = label;
        s_hv    = hv;
        if (mode) exp_q.push_back(^hv);
        @(negedge clk);
        s_valid = 1'b0;
        s_hv    = ~hv;
        s_label = ~label;
    endtask

    // Wait for r_valid (bounded); latency counted in negedges after the accept edge
    task automatic wait_result(output int lat);
        int op_low = 0;
        lat = 1;
        while (!r_valid && lat < 30) begin
            if (!cls_op) op_low++;
            @(negedge clk);
            lat++;
        end
        check("result_valid", 32'(r_valid), 32'd1);
        check("op_high_in_wait", 32'(op_low), 32'd0);
    endtask

    // Pop the scoreboard on the handshake and step past it
    task automatic take_result();
        logic exp;
        exp = 1'b0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check("r_label", 32'(r_label), 32'(exp));
        @(negedge clk);
        check("r_valid_drop", 32'(r_valid), 32'd0);
    endtask

    typedef struct {
        logic          mode;
        logic          label;
        logic [DW-1:0] hv;
        logic          exp_tl;
        logic [15:0]   exp_ns;
        logic [15:0]   exp_s;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   lat, acc, pulses, first_acc, last_acc;
        logic held;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0001, 1'b1, 16'd1, 16'd4};
        vecs[1] = '{1'b0, 1'b0, 32'hA5A5_0F0F, 1'b0, 16'd2, 16'd4};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0003, 1'b0, 16'd2, 16'd4};
        vecs[3] = '{1'b0, 1'b1, 32'h1234_5678, 1'b1, 16'd2, 16'd5};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0007, 1'b1, 16'd2, 16'd5};
        vecs[5] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 16'd3, 16'd5};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cls_op", 32'(cls_op), 32'd1);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cls_hv", cls_hv, 32'd0);
        nrst = 1'b0;
        @(negedge clk);
        check("idle_s_ready", 32'(s_ready), 32'd1);
        check("idle_cnt_ns", 32'(train_cnt_ns), 32'd0);

        // Single non-seizure training sample
        send(1'b0, 1'b0, 32'hCAFE_0001);
        check("train_op_low", 32'(cls_op), 32'd0);
        check("train_tl", 32'(cls_trained_label), 32'd0);
        check("train_hv", cls_hv, 32'hCAFE_0001);
        check("train_s_ready", 32'(s_ready), 32'd0);
        check("train_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("train_op_back", 32'(cls_op), 32'd1);
        check("train_cnt_ns1", 32'(train_cnt_ns), 32'd1);
        check("train_s_ready_back", 32'(s_ready), 32'd1);

        // Back-to-back seizure samples with s_valid held
        acc = 0; pulses = 0; first_acc = -1; last_acc = -1;
        s_valid = 1'b1; s_mode = 1'b0; s_label = 1'b1; s_hv = 32'h0F0F_0F0F;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (acc == 4) s_valid = 1'b0;
            else if (s_ready) begin
                acc++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            @(negedge clk);
            if (!cls_op) pulses++;
        end
        s_valid = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd4);
        check("b2b_spacing", 32'(last_acc - first_acc), 32'd6);
        check("b2b_cnt_s", 32'(train_cnt_s), 32'd4);
        check("b2b_cnt_ns", 32'(train_cnt_ns), 32'd1);
        check("sat_cnt_s_w2", 32'(d2_cnt_s), 32'd3);

        // Table of mixed samples
        r_ready = 1'b1;
        foreach (vecs[i]) begin
            send(vecs[i].mode, vecs[i].label, vecs[i].hv);
            if (vecs[i].mode) begin
                wait_result(lat);
                check($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
                take_result();
            end else begin
                @(negedge clk);
            end
            check($sformatf("v%0d_tl", i), 32'(cls_trained_label), 32'(vecs[i].exp_tl));
            check($sformatf("v%0d_cnt_ns", i), 32'(train_cnt_ns), 32'(vecs[i].exp_ns));
            check($sformatf("v%0d_cnt_s", i), 32'(train_cnt_s), 32'(vecs[i].exp_s));
        end

        // Saturation at CNT_W=2: ns keeps counting on the wide instance only
        repeat (2) begin
            send(1'b0, 1'b0, 32'h0000_00AA);
            @(negedge clk);
        end
        check("sat_cnt_ns_w16", 32'(train_cnt_ns), 32'd5);
        check("sat_cnt_ns_w2", 32'(d2_cnt_ns), 32'd3);

        // Result backpressure with a waiting sample
        r_ready = 1'b0;
        send(1'b1, 1'b0, 32'h0000_0101);
        wait_result(lat);
        held = r_label;
        s_valid = 1'b1; s_mode = 1'b0; s_label = 1'b1; s_hv = 32'h5555_AAAA;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_r_valid", 32'(r_valid), 32'd1);
            check("bp_r_label", 32'(r_label), 32'(held));
            check("bp_s_ready", 32'(s_ready), 32'd0);
        end
        r_ready = 1'b1;
        take_result();
        check("bp_idle_ready", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        check("bp_next_accept", 32'(cls_op), 32'd0);
        check("bp_next_hv", cls_hv, 32'h5555_AAAA);
        @(negedge clk);

        // Clear coinciding with TRAIN completion
        send(1'b0, 1'b0, 32'h0000_0F00);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clr_cnt_ns", 32'(train_cnt_ns), 32'd0);
        check("clr_cnt_s", 32'(train_cnt_s), 32'd0);
        check("clr_cnt_ns_w2", 32'(d2_cnt_ns), 32'd0);

        // Reset during WAIT drops the inference
        send(1'b0, 1'b1, 32'h0000_0011);
        @(negedge clk);
        send(1'b1, 1'b0, 32'h0000_0001);
        nrst = 1'b1;
        #1;
        check("rstw_cls_op", 32'(cls_op), 32'd1);
        check("rstw_r_valid", 32'(r_valid), 32'd0);
        check("rstw_s_ready", 32'(s_ready), 32'd0);
        check("rstw_cnt_s", 32'(train_cnt_s), 32'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        nrst = 1'b0;
        repeat (4) @(negedge clk);
        check("rstw_no_stale", 32'(r_valid), 32'd0);
        check("rstw_idle", 32'(s_ready), 32'd1);

        // Reset during TRAIN: sample is not counted
        send(1'b0, 1'b0, 32'h0000_0022);
        check("rstt_in_train", 32'(cls_op), 32'd0);
        nrst = 1'b1;
        #1;
        check("rstt_cls_op", 32'(cls_op), 32'd1);
        check("rstt_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        check("rstt_cnt_ns", 32'(train_cnt_ns), 32'd0);
        check("rstt_idle", 32'(s_ready), 32'd1);
        check("rstt_busy", 32'(busy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
